// File: rtl/pong_game_if.sv
// Pixel-stream link between the VGA timing generator (master) and the Pong pixel source (slave).
interface pong_game_if;
    logic [10:0] curr_x;
    logic [10:0] curr_y;
    logic [3:0]  r;
    logic [3:0]  g;
    logic [3:0]  b;

    modport master (output curr_x, output curr_y, input r, input g, input b);
    modport slave  (input curr_x, input curr_y, output r, output g, output b);
endinterface

// File: rtl/pong_game.sv
// Pong game logic and pixel source; all game state advances once per frame tick.
// Optional feature: define PONG_AI_EN to have the CPU drive the right paddle.
module pong_game #(
    parameter int H_ACTIVE     = 1280,
    parameter int V_ACTIVE     = 800,
    parameter int PADDLE_W     = 16,
    parameter int PADDLE_H     = 128,
    parameter int PADDLE_XL    = 32,
    parameter int PADDLE_XR    = 1232,
    parameter int BALL_SIZE    = 16,
    parameter int BALL_SPEED   = 4,
    parameter int PADDLE_SPEED = 8,
    parameter int SCORE_MAX    = 9
) (
    input  logic       clk,
    input  logic       rst,
    pong_game_if.slave vga,
    input  logic       btn_l_up,
    input  logic       btn_l_dn,
    input  logic       btn_r_up,
    input  logic       btn_r_dn,
    input  logic       btn_start,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic       game_over
);
    localparam logic [10:0] X_LAST  = 11'(H_ACTIVE - 1);
    localparam logic [10:0] Y_LAST  = 11'(V_ACTIVE - 1);
    localparam logic [10:0] H_ACT   = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT   = 11'(V_ACTIVE);
    localparam logic [10:0] PAD_W   = 11'(PADDLE_W);
    localparam logic [10:0] PAD_H   = 11'(PADDLE_H);
    localparam logic [10:0] PAD_XL  = 11'(PADDLE_XL);
    localparam logic [10:0] PAD_XR  = 11'(PADDLE_XR);
    localparam logic [10:0] PAD_SPD = 11'(PADDLE_SPEED);
    localparam logic [10:0] PAD_MAX = 11'(V_ACTIVE - PADDLE_H);
    localparam logic [10:0] PAD_Y0  = 11'((V_ACTIVE - PADDLE_H) / 2);
    localparam logic [10:0] B_SIZE  = 11'(BALL_SIZE);
    localparam logic [10:0] B_SPD   = 11'(BALL_SPEED);
    localparam logic [10:0] BALL_X0 = 11'((H_ACTIVE - BALL_SIZE) / 2);
    localparam logic [10:0] BALL_Y0 = 11'((V_ACTIVE - BALL_SIZE) / 2);
    localparam logic [10:0] Y_FLOOR = 11'(V_ACTIVE - BALL_SIZE);
    localparam logic [10:0] L_FACE  = 11'(PADDLE_XL + PADDLE_W);
    localparam logic [10:0] R_FACE  = 11'(PADDLE_XR - BALL_SIZE);
    localparam logic [3:0]  S_MAX   = 4'(SCORE_MAX);
    localparam logic [5:0]  SERVE_LAST = 6'd29;
    localparam logic [5:0]  POINT_LAST = 6'd59;

    typedef enum logic [2:0] {IDLE, SERVE, PLAY, POINT, OVER} state_t;

    state_t      state_q;
    logic [3:0]  scoreL_q, scoreR_q;
    logic        gameOver_q;
    logic [10:0] padL_q, padR_q, padL_d, padR_d;
    logic [10:0] ballX_q, ballY_q, ballX_d, ballY_d;
    logic        ballDxRight_q, ballDyDown_q, ballDxRight_d, ballDyDown_d;
    logic [5:0]  frameCnt_q;
    logic [4:0]  btnMeta_q, btnSync_q;
    logic        startPrev_q;
    logic        startPulse, tick;
    logic        overlapL, overlapR, missL, missR;
    logic        inBall, inPadL, inPadR, inLine;
    logic [11:0] colour;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btnMeta_q   <= '0;
            btnSync_q   <= '0;
            startPrev_q <= 1'b0;
        end else begin
            btnMeta_q   <= {btn_start, btn_r_dn, btn_r_up, btn_l_dn, btn_l_up};
            btnSync_q   <= btnMeta_q;
            startPrev_q <= btnSync_q[4];
        end
    end

    assign startPulse = btnSync_q[4] & ~startPrev_q;
    assign tick       = (vga.curr_x == X_LAST) && (vga.curr_y == Y_LAST);

    // Compare before stepping so the clamp never wraps.
    function automatic logic [10:0] padStep(input logic [10:0] y, input logic up, input logic dn);
        logic [10:0] res;
        res = y;
        if (up && !dn) begin
            res = (y >= PAD_SPD) ? y - PAD_SPD : 11'd0;
        end else if (dn && !up) begin
            res = (y + PAD_SPD <= PAD_MAX) ? y + PAD_SPD : PAD_MAX;
        end
        return res;
    endfunction

`ifdef PONG_AI_EN
    logic aiUp, aiDn;
    assign aiUp = (ballY_q + (B_SIZE >> 1)) < (padR_q + (PAD_H >> 1) - 11'd8);
    assign aiDn = (ballY_q + (B_SIZE >> 1)) > (padR_q + (PAD_H >> 1) + 11'd8);
    assign padR_d = padStep(padR_q, aiUp, aiDn);
`else
    assign padR_d = padStep(padR_q, btnSync_q[2], btnSync_q[3]);
`endif
    assign padL_d = padStep(padL_q, btnSync_q[0], btnSync_q[1]);

    always_comb begin
        ballY_d      = ballY_q;
        ballDyDown_d = ballDyDown_q;
        if (!ballDyDown_q && ballY_q <= B_SPD) begin
            ballY_d      = 11'd0;
            ballDyDown_d = 1'b1;
        end else if (ballDyDown_q && (ballY_q + B_SIZE + B_SPD >= V_ACT)) begin
            ballY_d      = Y_FLOOR;
            ballDyDown_d = 1'b0;
        end else if (ballDyDown_q) begin
            ballY_d = ballY_q + B_SPD;
        end else begin
            ballY_d = ballY_q - B_SPD;
        end

        // Paddle overlap uses the pre-bounce y.
        overlapL = (ballY_q + B_SIZE > padL_q) && (ballY_q < padL_q + PAD_H);
        overlapR = (ballY_q + B_SIZE > padR_q) && (ballY_q < padR_q + PAD_H);

        ballX_d       = ballX_q;
        ballDxRight_d = ballDxRight_q;
        missL         = 1'b0;
        missR         = 1'b0;
        if (!ballDxRight_q && ballX_q >= L_FACE && ballX_q <= L_FACE + B_SPD && overlapL) begin
            ballX_d       = L_FACE;
            ballDxRight_d = 1'b1;
        end else if (ballDxRight_q && ballX_q <= R_FACE && ballX_q >= R_FACE - B_SPD && overlapR) begin
            ballX_d       = R_FACE;
            ballDxRight_d = 1'b0;
        end else if (!ballDxRight_q && ballX_q <= B_SPD) begin
            missL = 1'b1;
        end else if (ballDxRight_q && (ballX_q + B_SIZE + B_SPD >= H_ACT)) begin
            missR = 1'b1;
        end else if (ballDxRight_q) begin
            ballX_d = ballX_q + B_SPD;
        end else begin
            ballX_d = ballX_q - B_SPD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            scoreL_q      <= '0;
            scoreR_q      <= '0;
            gameOver_q    <= 1'b0;
            padL_q        <= PAD_Y0;
            padR_q        <= PAD_Y0;
            ballX_q       <= BALL_X0;
            ballY_q       <= BALL_Y0;
            ballDxRight_q <= 1'b1;
            ballDyDown_q  <= 1'b1;
            frameCnt_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE, OVER: begin
                    if (startPulse) begin
                        state_q    <= SERVE;
                        scoreL_q   <= '0;
                        scoreR_q   <= '0;
                        gameOver_q <= 1'b0;
                        frameCnt_q <= '0;
                        ballX_q    <= BALL_X0;
                        ballY_q    <= BALL_Y0;
                    end
                end
                SERVE: begin
                    if (tick) begin
                        padL_q  <= padL_d;
                        padR_q  <= padR_d;
                        ballX_q <= BALL_X0;
                        ballY_q <= BALL_Y0;
                        if (frameCnt_q == SERVE_LAST) begin
                            state_q    <= PLAY;
                            frameCnt_q <= '0;
                        end else begin
                            frameCnt_q <= frameCnt_q + 6'd1;
                        end
                    end
                end
                PLAY: begin
                    if (tick) begin
                        padL_q        <= padL_d;
                        padR_q        <= padR_d;
                        ballX_q       <= ballX_d;
                        ballY_q       <= ballY_d;
                        ballDxRight_q <= ballDxRight_d;
                        ballDyDown_q  <= ballDyDown_d;
                        // The next serve heads toward whoever conceded.
                        if (missL) begin
                            state_q       <= POINT;
                            frameCnt_q    <= '0;
                            ballDxRight_q <= 1'b0;
                            scoreR_q      <= (scoreR_q >= S_MAX) ? S_MAX : scoreR_q + 4'd1;
                        end else if (missR) begin
                            state_q       <= POINT;
                            frameCnt_q    <= '0;
                            ballDxRight_q <= 1'b1;
                            scoreL_q      <= (scoreL_q >= S_MAX) ? S_MAX : scoreL_q + 4'd1;
                        end
                    end
                end
                POINT: begin
                    if (tick) begin
                        if (frameCnt_q == POINT_LAST) begin
                            frameCnt_q <= '0;
                            if (scoreL_q == S_MAX || scoreR_q == S_MAX) begin
                                state_q    <= OVER;
                                gameOver_q <= 1'b1;
                            end else begin
                                state_q <= SERVE;
                                ballX_q <= BALL_X0;
                                ballY_q <= BALL_Y0;
                            end
                        end else begin
                            frameCnt_q <= frameCnt_q + 6'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign score_l   = scoreL_q;
    assign score_r   = scoreR_q;
    assign game_over = gameOver_q;

    always_comb begin
        inBall = (vga.curr_x >= ballX_q) && (vga.curr_x < ballX_q + B_SIZE) &&
                 (vga.curr_y >= ballY_q) && (vga.curr_y < ballY_q + B_SIZE);
        inPadL = (vga.curr_x >= PAD_XL) && (vga.curr_x < PAD_XL + PAD_W) &&
                 (vga.curr_y >= padL_q) && (vga.curr_y < padL_q + PAD_H);
        inPadR = (vga.curr_x >= PAD_XR) && (vga.curr_x < PAD_XR + PAD_W) &&
                 (vga.curr_y >= padR_q) && (vga.curr_y < padR_q + PAD_H);
        inLine = (vga.curr_x >= 11'd638) && (vga.curr_x <= 11'd641) && !vga.curr_y[4];
        colour = 12'h000;
        if (inBall) begin
            colour = 12'hFF0;
        end else if (inPadL || inPadR) begin
            colour = 12'hFFF;
        end else if (inLine) begin
            colour = 12'h888;
        end
    end

    assign vga.r = colour[11:8];
    assign vga.g = colour[7:4];
    assign vga.b = colour[3:0];
endmodule

// File: tb/tb_pong_game.sv
// Directed bench for pong_game: the bench plays the timing generator and steps frames directly.
module tb_pong_game;
    logic clk = 1'b0;
    logic rst;
    logic btn_l_up, btn_l_dn, btn_r_up, btn_r_dn, btn_start;
    logic [3:0] score_l, score_r;
    logic game_over;
    int checkCount = 0;
    int failCount  = 0;

    pong_game_if vga();

    pong_game dut (
        .clk       (clk),
        .rst       (rst),
        .vga       (vga),
        .btn_l_up  (btn_l_up),
        .btn_l_dn  (btn_l_dn),
        .btn_r_up  (btn_r_up),
        .btn_r_dn  (btn_r_dn),
        .btn_start (btn_start),
        .score_l   (score_l),
        .score_r   (score_r),
        .game_over (game_over)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int x, input int y);
        vga.curr_x = 11'(x);
        vga.curr_y = 11'(y);
    endtask

    // Holding the last active pixel makes every clock a frame tick.
    task automatic tickFrames(input int n);
        applyStimulus(1279, 799);
        repeat (n) @(negedge clk);
        applyStimulus(0, 0);
    endtask

    task automatic setButtons(input logic [3:0] btns);
        {btn_r_dn, btn_r_up, btn_l_dn, btn_l_up} = btns;
        repeat (3) @(negedge clk);
    endtask

    task automatic pressStart();
        btn_start = 1'b1;
        repeat (4) @(negedge clk);
        btn_start = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic checkPixel(input string tag, input int x, input int y, input int expected);
        applyStimulus(x, y);
        #1;
        checkOutput(tag, int'({vga.r, vga.g, vga.b}), expected);
    endtask

    task automatic checkBall(input string tag, input int x, input int y);
        checkOutput({tag, "_x"}, int'(dut.ballX_q), x);
        checkOutput({tag, "_y"}, int'(dut.ballY_q), y);
    endtask

    initial begin
        rst = 1'b1;
        {btn_l_up, btn_l_dn, btn_r_up, btn_r_dn, btn_start} = '0;
        applyStimulus(0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        checkOutput("rst_state", int'(dut.state_q), 0);
        checkOutput("rst_score_l", int'(score_l), 0);
        checkOutput("rst_score_r", int'(score_r), 0);
        checkOutput("rst_game_over", int'(game_over), 0);
        checkOutput("rst_pad_l", int'(dut.padL_q), 336);
        checkOutput("rst_pad_r", int'(dut.padR_q), 336);
        checkBall("rst_ball", 632, 392);
        checkPixel("pix_ball", 632, 392, 'hFF0);
        checkPixel("pix_ball_over_line", 639, 392, 'hFF0);
        checkPixel("pix_ball_edge", 648, 392, 'h000);
        checkPixel("pix_line", 639, 0, 'h888);
        checkPixel("pix_line_gap", 639, 16, 'h000);
        checkPixel("pix_pad_l", 40, 350, 'hFFF);
        checkPixel("pix_pad_l_edge", 48, 350, 'h000);
        checkPixel("pix_pad_r", 1240, 400, 'hFFF);
        applyStimulus(0, 0);
        @(negedge clk);

        tickFrames(5);
        checkOutput("idle_hold_state", int'(dut.state_q), 0);
        checkBall("idle_hold_ball", 632, 392);

        pressStart();
        checkOutput("start_state", int'(dut.state_q), 1);

        setButtons(4'b1001);
        tickFrames(20);
        checkOutput("serve_pad_l_up", int'(dut.padL_q), 176);
        checkOutput("serve_pad_r_dn", int'(dut.padR_q), 496);
        checkBall("serve_ball_held", 632, 392);
        setButtons(4'b0011);
        tickFrames(5);
        checkOutput("both_btn_hold", int'(dut.padL_q), 176);
        setButtons(4'b0000);
        tickFrames(4);
        checkOutput("serve_29", int'(dut.state_q), 1);
        tickFrames(1);
        checkOutput("serve_30_play", int'(dut.state_q), 2);
        checkBall("play_start", 632, 392);
        tickFrames(1);
        checkBall("play_first_step", 636, 396);

        tickFrames(96);
        checkBall("pre_floor", 1020, 780);
        tickFrames(1);
        checkBall("floor_bounce", 1024, 784);
        checkOutput("floor_dy", int'(dut.ballDyDown_q), 0);

        tickFrames(48);
        checkBall("hit_r", 1216, 592);
        checkOutput("hit_r_dx", int'(dut.ballDxRight_q), 0);
        checkPixel("pix_ball_by_pad", 1231, 600, 'hFF0);
        checkPixel("pix_pad_by_ball", 1232, 600, 'hFFF);
        applyStimulus(0, 0);
        @(negedge clk);

        tickFrames(148);
        checkBall("ceiling_bounce", 624, 0);
        checkOutput("ceiling_dy", int'(dut.ballDyDown_q), 1);
        tickFrames(155);
        checkBall("pre_miss_l", 4, 620);
        checkOutput("pre_miss_score_r", int'(score_r), 0);
        tickFrames(1);
        checkOutput("miss_l_state", int'(dut.state_q), 3);
        checkOutput("miss_l_score_r", int'(score_r), 1);
        checkBall("miss_l_frozen", 4, 624);
        tickFrames(59);
        checkOutput("point_59", int'(dut.state_q), 3);
        tickFrames(1);
        checkOutput("point_60_serve", int'(dut.state_q), 1);
        checkOutput("serve_dx_left", int'(dut.ballDxRight_q), 0);
        checkBall("serve2_ball", 632, 392);

        setButtons(4'b0010);
        tickFrames(30);
        checkOutput("serve2_play", int'(dut.state_q), 2);
        checkOutput("serve2_pad_l", int'(dut.padL_q), 416);
        tickFrames(10);
        checkOutput("play_pad_l", int'(dut.padL_q), 496);
        checkBall("rally2_j10", 592, 432);
        setButtons(4'b0000);
        tickFrames(135);
        checkBall("pre_hit_l", 52, 596);
        tickFrames(1);
        checkBall("hit_l", 48, 592);
        checkOutput("hit_l_dx", int'(dut.ballDxRight_q), 1);
        checkOutput("hit_l_score_r", int'(score_r), 1);
        checkOutput("hit_l_score_l", int'(score_l), 0);

        checkPixel("pix_pre_reset", 40, 350, 'h000);
        rst = 1'b1;
        #1;
        checkPixel("pix_async_reset", 40, 350, 'hFFF);
        checkOutput("async_rst_state", int'(dut.state_q), 0);
        checkOutput("async_rst_score_r", int'(score_r), 0);
        checkOutput("async_rst_pad_l", int'(dut.padL_q), 336);
        checkBall("async_rst_ball", 632, 392);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(0, 0);
        @(negedge clk);

        pressStart();
        for (int i = 0; i < 9; i++) begin
            tickFrames(188);
            checkOutput("miss_r_state", int'(dut.state_q), 3);
            checkOutput("miss_r_score_l", int'(score_l), i + 1);
            checkOutput("miss_r_x", int'(dut.ballX_q), 1260);
            tickFrames(60);
            checkOutput("after_point_state", int'(dut.state_q), (i < 8) ? 1 : 4);
            checkOutput("after_point_game_over", int'(game_over), (i < 8) ? 0 : 1);
        end
        tickFrames(3);
        checkOutput("over_hold", int'(dut.state_q), 4);
        checkOutput("over_score_l", int'(score_l), 9);
        pressStart();
        checkOutput("restart_state", int'(dut.state_q), 1);
        checkOutput("restart_score_l", int'(score_l), 0);
        checkOutput("restart_game_over", int'(game_over), 0);

        setButtons(4'b1001);
        tickFrames(42);
        checkOutput("clamp_top", int'(dut.padL_q), 0);
        checkOutput("clamp_bottom", int'(dut.padR_q), 672);
        tickFrames(3);
        checkOutput("clamp_top_hold", int'(dut.padL_q), 0);
        checkOutput("clamp_bottom_hold", int'(dut.padR_q), 672);
        setButtons(4'b0000);
        checkPixel("pix_pad_top", 40, 0, 'hFFF);
        checkPixel("pix_pad_top_end", 40, 128, 'h000);
        checkPixel("pix_pad_bottom", 1240, 672, 'hFFF);
        checkPixel("pix_pad_bottom_above", 1240, 671, 'h000);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end
endmodule

// File: doc/pong_game.md
Name: pong_game

Overview:
- Pixel-source and game-logic stage directly upstream of the VGA timing generator.
- Consumes the generator's active-area coordinates (curr_x, curr_y) and drives its r/g/b inputs.
- Holds Pong state: two paddles, ball, scores, and game FSM; all game state advances once per frame.

Parameters:
- H_ACTIVE, 1280, active pixels per line
- V_ACTIVE, 800, active lines per frame
- PADDLE_W, 16, paddle width in px
- PADDLE_H, 128, paddle height in px
- PADDLE_XL, 32, left edge x of left paddle
- PADDLE_XR, 1232, left edge x of right paddle
- BALL_SIZE, 16, ball side in px (square)
- BALL_SPEED, 4, ball px per frame per axis
- PADDLE_SPEED, 8, paddle px per frame
- SCORE_MAX, 9, winning score

Ports:
- clk  in  1  pixel clock, same clock as the VGA timing generator
- rst  in  1  asynchronous, active-high reset
- curr_x  in  11  active x from the timing generator
- curr_y  in  11  active y from the timing generator
- btn_l_up, btn_l_dn, btn_r_up, btn_r_dn, btn_start  in  1 each  raw asynchronous buttons
- r, g, b  out  4 each  pixel colour to the timing generator
- score_l, score_r  out  4 each  scores
- game_over  out  1  high in OVER state

Behaviour:
- Reset (async, active-high):
  - state=IDLE, scores=0, game_over=0.
  - Paddle y = (V_ACTIVE-PADDLE_H)/2 = 336.
  - Ball = (632, 392); dx=right, dy=down; frame counter=0.
- Input synchronisation: every button passes through a 2-FF synchroniser. btn_start is then rising-edge detected, giving a 1-cycle pulse.
- Frame tick: combinational, true when curr_x==H_ACTIVE-1 and curr_y==V_ACTIVE-1. Exactly one cycle per frame.
  - All ball, paddle, score and FSM updates occur only on clk edges where tick=1.
  - Exception: start-pulse transitions, which occur on any cycle.
- FSM:
  - IDLE: on start pulse, scores cleared and state -> SERVE.
  - SERVE: ball held centred; frame counter counts 30 ticks, then -> PLAY.
  - PLAY: ball moves by BALL_SPEED on each axis per tick.
  - POINT: ball frozen for 60 ticks.
    - If either score == SCORE_MAX -> OVER, else -> SERVE.
    - Serve direction is toward the player who conceded.
  - OVER: game_over=1; start pulse -> SERVE with scores cleared.
- Paddles: move on tick in SERVE and PLAY only.
  - Up: y -= PADDLE_SPEED. Down: y += PADDLE_SPEED.
  - Clamped to [0, V_ACTIVE-PADDLE_H] with no wrap.
  - Up and down both pressed, or neither: no motion.
- Ball, per tick in PLAY; checks evaluated in the order listed:
  - Vertical:
    - If moving up and y <= BALL_SPEED: y=0, dy=down.
    - If moving down and y+BALL_SIZE+BALL_SPEED >= V_ACTIVE: y = V_ACTIVE-BALL_SIZE, dy=up.
    - Otherwise step.
  - Left paddle:
    - Applies when moving left, x >= PADDLE_XL+PADDLE_W, x <= PADDLE_XL+PADDLE_W+BALL_SPEED, and vertical overlap holds (ball_y+BALL_SIZE > pad_y and ball_y < pad_y+PADDLE_H).
    - Result: x = PADDLE_XL+PADDLE_W, dx=right.
  - Right paddle: mirror of the left, using PADDLE_XR; result x = PADDLE_XR-BALL_SIZE, dx=left.
  - Miss:
    - Moving left and x <= BALL_SPEED: score_r+1, -> POINT.
    - Moving right and x+BALL_SIZE+BALL_SPEED >= H_ACTIVE: score_l+1, -> POINT.
    - Scores saturate at SCORE_MAX.
  - Vertical and horizontal updates apply in the same tick; the vertical bounce uses the old y for the overlap test.
- Arithmetic: all positions are 11-bit unsigned. Compare before subtracting so no underflow can occur.
- Colour:
  - Combinational from curr_x, curr_y and registered state; zero latency, so the pixel aligns with the generator's masking.
  - Priority: ball (F,F,0) > paddles (F,F,F) > centre line (8,8,8) > background (0,0,0).
  - Centre line: 638 <= x <= 641 and curr_y[4]==0.
  - Shapes are half-open: [pos, pos+size).
- Reset mid-operation: the async reset immediately returns all state to the reset values; colour follows the reset scene in the same cycle.

Optional Feature:
- Macro: PONG_AI_EN.
- Defined:
  - Right paddle is CPU-controlled and btn_r_up/btn_r_dn are ignored.
  - Each tick in SERVE/PLAY: if ball centre < paddle centre-8, move up; if > paddle centre+8, move down; else hold.
  - Same speed and clamping as manual control.
- Undefined: both paddles are button-driven as described above.

Test Plan:
- Reset asserted mid-PLAY with ball at (100,50) -> same cycle: ball (632,392), paddles y=336, scores 0, game_over=0, state IDLE.
- Start pulse, then 30 ticks -> PLAY; after 1 more tick ball (636,396).
- Ball y=2, moving up, tick -> y=0, dy=down; ball at y=797, moving down -> y=784, dy=up.
- Left paddle y=300, ball (50,350) moving left, tick -> x=48, dx=right, no score change. Same setup with paddle y=0 -> ball continues; at x<=4 score_r=1, state POINT; after 60 ticks SERVE with dx=left.
- Drive 9 misses past the left paddle -> score_r=9, game_over=1 after the POINT hold; start pulse -> scores 0, SERVE.
- Left paddle at y=4, up held, tick -> y=0, stays 0; both buttons held -> no change; render at (40,350) with paddle y=300 -> rgb F,F,F; at (639,0) -> 8,8,8.
